// File: rtl/hsm_frame_assembler.sv
// Frame assembler between gpio_hsm and the crypto core: gathers key and data
// bytes big-endian, launches the core, then returns the result one byte per read.
module hsm_frame_assembler #(
   parameter int DATA_WIDTH  = 8,
   parameter int BLOCK_BYTES = 16
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [DATA_WIDTH-1:0]             in_data,
   input  logic                              in_valid,
   input  logic                              in_is_key,
   output logic [DATA_WIDTH*BLOCK_BYTES-1:0] key_out,
   output logic [DATA_WIDTH*BLOCK_BYTES-1:0] blk_out,
   output logic                              start,
   input  logic                              core_busy,
   input  logic                              core_done,
   input  logic [DATA_WIDTH*BLOCK_BYTES-1:0] core_result,
   input  logic                              rd_req,
   output logic [DATA_WIDTH-1:0]             rd_data,
   output logic                              rd_valid,
   output logic                              key_loaded,
   output logic                              err
);

   localparam int TOT_W = DATA_WIDTH * BLOCK_BYTES;
   localparam int CNT_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_BYTES - 1);

   localparam logic [1:0] S_FILL  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]       state;
   logic [CNT_W-1:0] key_cnt;
   logic [CNT_W-1:0] blk_cnt;
   logic [CNT_W-1:0] rd_cnt;
   logic [TOT_W-1:0] key_reg;
   logic [TOT_W-1:0] blk_reg;
   logic [TOT_W-1:0] result_reg;

   logic key_wr;
   logic dat_wr;
   logic drop;

   // Byte index 0 is the most significant byte of a block.
   function automatic int byte_lsb(input logic [CNT_W-1:0] idx);
      return (BLOCK_BYTES - 1 - int'(idx)) * DATA_WIDTH;
   endfunction

   assign key_wr = in_valid & in_is_key & (state == S_FILL);
   assign dat_wr = in_valid & ~in_is_key & (state == S_FILL) & key_loaded;
   assign drop   = in_valid & ~(key_wr | dat_wr);

   // Launch is combinational so it fires in the first non-busy ISSUE cycle.
   assign start   = (state == S_ISSUE) & ~core_busy;
   assign key_out = key_reg;
   assign blk_out = blk_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_FILL;
         key_cnt    <= '0;
         blk_cnt    <= '0;
         rd_cnt     <= '0;
         key_reg    <= '0;
         blk_reg    <= '0;
         result_reg <= '0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         key_loaded <= 1'b0;
         err        <= 1'b0;
      end else begin
         rd_valid <= 1'b0;

         if (drop)
            err <= 1'b1;

         // A key byte at position 0 invalidates whatever key was held.
         if (key_wr) begin
            key_reg[byte_lsb(key_cnt) +: DATA_WIDTH] <= in_data;
            if (key_cnt == '0)
               key_loaded <= 1'b0;
            if (key_cnt == LAST) begin
               key_cnt    <= '0;
               key_loaded <= 1'b1;
            end else begin
               key_cnt <= key_cnt + 1'b1;
            end
         end

         case (state)
            S_FILL: begin
               if (dat_wr) begin
                  blk_reg[byte_lsb(blk_cnt) +: DATA_WIDTH] <= in_data;
                  if (blk_cnt == LAST) begin
                     blk_cnt <= '0;
                     state   <= S_ISSUE;
                  end else begin
                     blk_cnt <= blk_cnt + 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (!core_busy)
                  state <= S_WAIT;
            end
            S_WAIT: begin
               if (core_done) begin
                  result_reg <= core_result;
                  rd_cnt     <= '0;
                  state      <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (rd_req) begin
                  rd_data  <= result_reg[byte_lsb(rd_cnt) +: DATA_WIDTH];
                  rd_valid <= 1'b1;
                  if (rd_cnt == LAST) begin
                     rd_cnt <= '0;
                     state  <= S_FILL;
                  end else begin
                     rd_cnt <= rd_cnt + 1'b1;
                  end
               end
            end
            default: state <= S_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_hsm_frame_assembler.sv
// Randomised scoreboard bench for hsm_frame_assembler: a byte-level model
// predicts launches and result bytes, a monitor checks them as they appear.
module tb_hsm_frame_assembler;

   localparam int W   = 8;
   localparam int BB  = 16;
   localparam int TOT = W * BB;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic [W-1:0]   in_data = '0;
   logic           in_valid = 1'b0;
   logic           in_is_key = 1'b0;
   logic [TOT-1:0] key_out;
   logic [TOT-1:0] blk_out;
   logic           start;
   logic           core_busy = 1'b0;
   logic           core_done = 1'b0;
   logic [TOT-1:0] core_result = '0;
   logic           rd_req = 1'b0;
   logic [W-1:0]   rd_data;
   logic           rd_valid;
   logic           key_loaded;
   logic           err;

   hsm_frame_assembler #(.DATA_WIDTH(W), .BLOCK_BYTES(BB)) dut (
      .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_is_key(in_is_key), .key_out(key_out), .blk_out(blk_out),
      .start(start), .core_busy(core_busy), .core_done(core_done),
      .core_result(core_result), .rd_req(rd_req), .rd_data(rd_data),
      .rd_valid(rd_valid), .key_loaded(key_loaded), .err(err)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int             cyc;
      logic [TOT-1:0] key;
      logic [TOT-1:0] blk;
   } start_t;
   typedef struct {
      int           cyc;
      logic [W-1:0] b;
   } rd_t;
   start_t start_q[$];
   rd_t    rd_q[$];

   // Reference model: byte positions, key/data acceptance and sticky error.
   logic [TOT-1:0] m_key_v, m_blk_v;
   int             m_key_n, m_blk_n;
   bit             m_loaded, m_err, m_filling;

   task automatic check(input string name, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic model_reset();
      m_key_v = '0; m_blk_v = '0; m_key_n = 0; m_blk_n = 0;
      m_loaded = 0; m_err = 0; m_filling = 1;
   endtask

   task automatic send_byte(input bit is_key, input logic [W-1:0] b);
      in_valid = 1'b1; in_is_key = is_key; in_data = b;
      if (!m_filling) m_err = 1;
      else if (is_key) begin
         if (m_key_n == 0) m_loaded = 0;
         m_key_v[TOT-1-W*m_key_n -: W] = b;
         m_key_n++;
         if (m_key_n == BB) begin m_key_n = 0; m_loaded = 1; end
      end else if (!m_loaded) m_err = 1;
      else begin
         m_blk_v[TOT-1-W*m_blk_n -: W] = b;
         m_blk_n++;
         if (m_blk_n == BB) begin m_blk_n = 0; m_filling = 0; end
      end
      tick();
      in_valid = 1'b0; in_is_key = 1'b0;
   endtask

   task automatic send_key(input bit fixed);
      for (int i = 0; i < BB; i++) begin
         if (!fixed) repeat ($urandom_range(0, 1)) tick();
         send_byte(1'b1, fixed ? W'(i) : W'($urandom));
      end
   endtask

   task automatic run_block(input bit fixed, input int busy_n);
      logic [TOT-1:0] res;
      start_t s;
      rd_t    r;
      for (int i = 0; i < BB; i++) begin
         if (!fixed) repeat ($urandom_range(0, 2)) tick();
         if (i == BB - 1) core_busy = (busy_n > 0);
         send_byte(1'b0, fixed ? W'(8'h10 + i) : W'($urandom));
      end
      repeat (busy_n) tick();
      core_busy = 1'b0;
      s.cyc = cyc; s.key = m_key_v; s.blk = m_blk_v;
      start_q.push_back(s);
      tick();
      check("wait_key_out", key_out, m_key_v);
      check("wait_blk_out", blk_out, m_blk_v);
      if (fixed || $urandom_range(0, 1) == 1) begin
         send_byte(1'($urandom_range(0, 1)), W'($urandom));
         check("wait_drop_err", TOT'(err), TOT'(1));
         check("wait_drop_blk", blk_out, m_blk_v);
         check("wait_drop_key", key_out, m_key_v);
      end
      rd_req = 1'b1; tick(); rd_req = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      if (fixed) for (int i = 0; i < BB; i++) res[TOT-1-W*i -: W] = W'(8'hA0 + i);
      else res = {$urandom, $urandom, $urandom, $urandom};
      core_result = res; core_done = 1'b1; tick(); core_done = 1'b0;
      for (int i = 0; i < BB; i++) begin
         if (!fixed) repeat ($urandom_range(0, 2)) tick();
         rd_req = 1'b1;
         r.cyc = cyc + 1; r.b = res[TOT-1-W*i -: W];
         rd_q.push_back(r);
         tick();
         rd_req = 1'b0;
      end
      m_filling = 1;
      rd_req = 1'b1; tick(); rd_req = 1'b0;
      tick(); tick();
      check("drain_pending", TOT'(rd_q.size()), TOT'(0));
      check("post_drain_err", TOT'(err), TOT'(m_err));
      check("post_drain_loaded", TOT'(key_loaded), TOT'(m_loaded));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_key_out"}, key_out, '0);
      check({tag, "_blk_out"}, blk_out, '0);
      check({tag, "_start"}, TOT'(start), '0);
      check({tag, "_rd_valid"}, TOT'(rd_valid), '0);
      check({tag, "_rd_data"}, TOT'(rd_data), '0);
      check({tag, "_key_loaded"}, TOT'(key_loaded), '0);
      check({tag, "_err"}, TOT'(err), '0);
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (start) begin
            if (start_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL start: unexpected pulse at cycle %0d", cyc);
            end else begin
               start_t s;
               s = start_q.pop_front();
               check("start_cycle", TOT'(cyc), TOT'(s.cyc));
               check("start_key", key_out, s.key);
               check("start_blk", blk_out, s.blk);
            end
         end
         if (rd_valid) begin
            if (rd_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL rd_valid: unexpected strobe at cycle %0d data %0h", cyc, rd_data);
            end else begin
               rd_t r;
               r = rd_q.pop_front();
               check("rd_cycle", TOT'(cyc), TOT'(r.cyc));
               check("rd_data", TOT'(rd_data), TOT'(r.b));
            end
         end
      end
   end

   initial begin
      model_reset();
      tick(); tick();
      @(negedge clock);
      check_zero("reset");
      tick();
      reset = 1'b0;
      tick();

      // Data before any key is dropped and flags the error.
      send_byte(1'b0, 8'h55);
      check("early_data_err", TOT'(err), TOT'(1));
      check("early_data_blk", blk_out, '0);
      check("early_data_loaded", TOT'(key_loaded), '0);

      send_key(1'b1);
      check("key_loaded_after_16", TOT'(key_loaded), TOT'(1));
      check("key_out_fixed", key_out, m_key_v);
      run_block(1'b1, 0);
      run_block(1'b0, 5);

      // Restarting a key mid-way leaves the assembler without a key.
      send_byte(1'b1, W'($urandom));
      check("rekey_cleared", TOT'(key_loaded), '0);
      for (int i = 0; i < 4; i++) send_byte(1'b1, W'($urandom));
      send_byte(1'b0, W'($urandom));
      check("rekey_drop_err", TOT'(err), TOT'(1));
      check("rekey_blk_same", blk_out, m_blk_v);
      for (int i = 5; i < BB; i++) begin
         check("rekey_partial", TOT'(key_loaded), '0);
         send_byte(1'b1, W'($urandom));
      end
      check("rekey_loaded", TOT'(key_loaded), TOT'(1));
      check("rekey_key_out", key_out, m_key_v);

      for (int it = 0; it < 5; it++) begin
         if ($urandom_range(0, 2) == 0) send_key(1'b0);
         core_result = {$urandom, $urandom, $urandom, $urandom};
         core_done = 1'b1; tick(); core_done = 1'b0;
         run_block(1'b0, $urandom_range(0, 5));
      end

      // Reset in the middle of a block aborts it with no launch.
      for (int i = 0; i < 6; i++) send_byte(1'b0, W'($urandom));
      @(posedge clock);
      #3 reset = 1'b1;
      @(negedge clock);
      check_zero("midreset");
      tick();
      reset = 1'b0;
      model_reset();
      tick();
      check_zero("post_reset");
      for (int i = 0; i < BB; i++) send_byte(1'b0, W'($urandom));
      check("nokey_err", TOT'(err), TOT'(1));
      check("nokey_blk", blk_out, '0);
      repeat (4) tick();

      check("start_pending", TOT'(start_q.size()), TOT'(0));
      check("rd_pending", TOT'(rd_q.size()), TOT'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
